// File: rtl/pixel_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// pixel_write_arbiter_if : request, clear and pixel-write signals of the arbiter
// Revision: 1.0
// ============================================================================
interface pixel_write_arbiter_if;
  logic        a_valid;
  logic [5:0]  a_x;
  logic [5:0]  a_y;
  logic [11:0] a_color;
  logic        a_ready;

  logic        b_valid;
  logic [5:0]  b_x;
  logic [5:0]  b_y;
  logic [11:0] b_color;
  logic        b_ready;

  logic        clear_req;
  logic        clear_busy;

  logic        write_en;
  logic [5:0]  write_x;
  logic [5:0]  write_y;
  logic [11:0] write_color;

  modport master (
    output a_valid, a_x, a_y, a_color, b_valid, b_x, b_y, b_color, clear_req,
    input  a_ready, b_ready, clear_busy, write_en, write_x, write_y, write_color
  );

  modport slave (
    input  a_valid, a_x, a_y, a_color, b_valid, b_x, b_y, b_color, clear_req,
    output a_ready, b_ready, clear_busy, write_en, write_x, write_y, write_color
  );
endinterface
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// pixel_write_arbiter : round-robin arbiter of two pixel writers, with an
//                       optional full-frame clear sweep (PIXEL_ARB_CLEAR_EN)
// Revision: 1.0
// ============================================================================
module pixel_write_arbiter #(
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pixel_write_arbiter_if.slave bus
);
  logic        w_block;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_clear_write;
  logic [11:0] w_clear_addr;
  logic        r_last_b;
  logic        r_write_en;
  logic [5:0]  r_write_x;
  logic [5:0]  r_write_y;
  logic [11:0] r_write_color;

`ifdef PIXEL_ARB_CLEAR_EN
  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_sweep;
  logic [11:0] w_sweep_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // Sweep counter wraps 4095 -> 0 on the final clear write, ready for the next clear
  always_comb begin
    w_state_nxt   = r_state;
    w_sweep_nxt   = '0;
    w_block       = 1'b0;
    w_clear_write = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_block       = 1'b1;
      w_clear_write = 1'b1;
      w_sweep_nxt   = r_sweep + 12'd1;
      if (r_sweep == 12'hFFF) begin
        w_state_nxt = ST_ARB;
      end
    end else if (bus.clear_req) begin
      w_block     = 1'b1;
      w_state_nxt = ST_CLEAR;
    end
  end

  assign w_clear_addr   = r_sweep;
  assign bus.clear_busy = (r_state == ST_CLEAR);
`else
  logic w_unused_clear;
  assign w_unused_clear = bus.clear_req;
  assign w_block        = 1'b0;
  assign w_clear_write  = 1'b0;
  assign w_clear_addr   = '0;
  assign bus.clear_busy = 1'b0;
`endif

  // r_last_b set means B was granted most recently, so A wins the next contention
  assign w_grant_a = ~w_block & bus.a_valid & (~bus.b_valid | r_last_b);
  assign w_grant_b = ~w_block & bus.b_valid & (~bus.a_valid | ~r_last_b);

  assign bus.a_ready = w_grant_a;
  assign bus.b_ready = w_grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_grant_a) begin
      r_last_b <= 1'b0;
    end else if (w_grant_b) begin
      r_last_b <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en    <= 1'b0;
      r_write_x     <= '0;
      r_write_y     <= '0;
      r_write_color <= '0;
    end else begin
      r_write_en <= w_grant_a | w_grant_b | w_clear_write;
      if (w_grant_a) begin
        r_write_x     <= bus.a_x;
        r_write_y     <= bus.a_y;
        r_write_color <= bus.a_color;
      end else if (w_grant_b) begin
        r_write_x     <= bus.b_x;
        r_write_y     <= bus.b_y;
        r_write_color <= bus.b_color;
      end else if (w_clear_write) begin
        r_write_x     <= w_clear_addr[5:0];
        r_write_y     <= w_clear_addr[11:6];
        r_write_color <= CLEAR_COLOR;
      end
    end
  end

  assign bus.write_en    = r_write_en;
  assign bus.write_x     = r_write_x;
  assign bus.write_y     = r_write_y;
  assign bus.write_color = r_write_color;
endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pixel_write_arbiter : directed stimulus with a write scoreboard
// Revision: 1.0
// ============================================================================
module tb_pixel_write_arbiter;
  localparam logic [11:0] CC = 12'h5A3;

  typedef struct packed {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] c;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  wr_t  a_dat[3];
  wr_t  b_dat[3];
  int   ai;
  int   bi;

  pixel_write_arbiter_if bus();

  pixel_write_arbiter #(.CLEAR_COLOR(CC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input wr_t d);
    bus.a_x = d.x; bus.a_y = d.y; bus.a_color = d.c;
  endtask

  task automatic drive_b(input wr_t d);
    bus.b_x = d.x; bus.b_y = d.y; bus.b_color = d.c;
  endtask

  // Monitor: every presented write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got (%0d,%0d,%0h) expected none at %0t",
                 bus.write_x, bus.write_y, bus.write_color, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_data", {8'h0, bus.write_x, bus.write_y, bus.write_color}, {8'h0, mon_e});
      end
    end
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
    bus.b_valid = 1'b0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
    bus.clear_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {7'h0, bus.write_en, bus.write_x, bus.write_y, bus.write_color},
        32'h0);
    chk("reset_busy", {31'h0, bus.clear_busy}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(); #3;
      chk("idle_outputs", {5'h0, bus.a_ready, bus.b_ready, bus.write_en, bus.write_x,
          bus.write_y, bus.write_color}, 32'h0);
      chk("idle_busy", {31'h0, bus.clear_busy}, 32'h0);
    end

    // Single A request
    bus.a_valid = 1'b1; drive_a('{6'd5, 6'd10, 12'hF00});
    #3;
    chk("single_a_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
    exp_q.push_back('{6'd5, 6'd10, 12'hF00});
    step();
    bus.a_valid = 1'b0; drive_a('{6'd0, 6'd0, 12'h000});
    step(); #3;
    chk("single_a_wen_off", {31'h0, bus.write_en}, 32'h0);
    chk("single_a_hold", {8'h0, bus.write_x, bus.write_y, bus.write_color},
        {8'h0, 6'd5, 6'd10, 12'hF00});

    // Asynchronous reset mid-cycle clears outputs at once
    rst_n = 1'b0;
    #1;
    chk("async_reset", {7'h0, bus.write_en, bus.write_x, bus.write_y, bus.write_color},
        32'h0);
    step();
    rst_n = 1'b1;

    // Both valid after reset: A, B, A, B
    a_dat[0] = '{6'd1, 6'd2, 12'h111}; a_dat[1] = '{6'd7, 6'd8, 12'h777};
    a_dat[2] = '{6'd13, 6'd14, 12'hDDD};
    b_dat[0] = '{6'd3, 6'd4, 12'h222}; b_dat[1] = '{6'd9, 6'd10, 12'h999};
    b_dat[2] = '{6'd15, 6'd16, 12'hEEE};
    ai = 0; bi = 0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(a_dat[ai]); drive_b(b_dat[bi]);
      #3;
      if (i % 2 == 0) begin
        chk("rr_ready_a", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
        exp_q.push_back(a_dat[ai]);
        step();
        ai++;
      end else begin
        chk("rr_ready_b", {30'h0, bus.a_ready, bus.b_ready}, 32'h1);
        exp_q.push_back(b_dat[bi]);
        step();
        bi++;
      end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();

    // B alone right after B was granted
    bus.b_valid = 1'b1; drive_b('{6'd63, 6'd0, 12'hABC});
    #3;
    chk("single_b_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h1);
    exp_q.push_back('{6'd63, 6'd0, 12'hABC});
    step();
    bus.b_valid = 1'b0;
    step();

    // A alone, then contention with last grant A -> B first, A stays pending
    bus.a_valid = 1'b1; drive_a('{6'd0, 6'd63, 12'hFFF});
    #3;
    chk("single_a2_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
    exp_q.push_back('{6'd0, 6'd63, 12'hFFF});
    step();
    drive_a('{6'd20, 6'd21, 12'h321});
    bus.b_valid = 1'b1; drive_b('{6'd30, 6'd31, 12'h654});
    #3;
    chk("rr_after_a", {30'h0, bus.a_ready, bus.b_ready}, 32'h1);
    exp_q.push_back('{6'd30, 6'd31, 12'h654});
    step();
    bus.b_valid = 1'b0;
    #3;
    chk("a_pending_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
    exp_q.push_back('{6'd20, 6'd21, 12'h321});
    step();
    bus.a_valid = 1'b0;
    step();

`ifdef PIXEL_ARB_CLEAR_EN
    // Clear with A waiting: sweep first, then A
    bus.clear_req = 1'b1;
    bus.a_valid = 1'b1; drive_a('{6'd11, 6'd22, 12'h456});
    #3;
    chk("clear_pri_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h0);
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back('{k[5:0], k[11:6], CC});
    end
    exp_q.push_back('{6'd11, 6'd22, 12'h456});
    step();
    bus.clear_req = 1'b0;
    for (int i = 1; i <= 4096; i++) begin
      #3;
      chk("clear_busy_on", {31'h0, bus.clear_busy}, 32'h1);
      chk("clear_ready_off", {30'h0, bus.a_ready, bus.b_ready}, 32'h0);
      step();
      bus.clear_req = (i == 2000);
    end
    #3;
    chk("clear_busy_done", {31'h0, bus.clear_busy}, 32'h0);
    chk("post_clear_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
    step();
    bus.a_valid = 1'b0;
    repeat (5) step();
    #3;
    chk("no_requeued_clear", {31'h0, bus.clear_busy}, 32'h0);

    // Reset during the sweep abandons it
    step();
    bus.clear_req = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back('{k[5:0], k[11:6], CC});
    end
    step();
    bus.clear_req = 1'b0;
    repeat (100) step();
    chk("clear_write100", {7'h0, bus.write_en, bus.write_x, bus.write_y, 12'h0},
        {7'h0, 1'b1, 6'd35, 6'd1, 12'h0});
    chk("clear_popped", exp_q.size(), 4096 - 99);
    rst_n = 1'b0;
    #1;
    chk("clear_reset_wen", {31'h0, bus.write_en}, 32'h0);
    chk("clear_reset_busy", {31'h0, bus.clear_busy}, 32'h0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); #3;
      chk("post_reset_busy", {31'h0, bus.clear_busy}, 32'h0);
    end
`else
    // Without the clear feature, clear_req has no effect on arbitration
    bus.clear_req = 1'b1;
    bus.a_valid = 1'b1; drive_a('{6'd2, 6'd3, 12'h123});
    #3;
    chk("noclear_ready", {30'h0, bus.a_ready, bus.b_ready}, 32'h2);
    chk("noclear_busy", {31'h0, bus.clear_busy}, 32'h0);
    exp_q.push_back('{6'd2, 6'd3, 12'h123});
    step();
    bus.a_valid = 1'b0;
    step(); #3;
    chk("noclear_busy2", {31'h0, bus.clear_busy}, 32'h0);
    bus.clear_req = 1'b0;
    repeat (5) step();
`endif

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_COLOR, default 12'h000: RGB444 colour written by the clear sweep.
REQ-002 SHALL have port clk  input  1: single clock, also the clock of the pixel memory write port.
REQ-003 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-004 SHALL have ports a_valid input 1, a_x input 6, a_y input 6, a_color input 12: requester A (physics renderer) write request.
REQ-005 SHALL have port a_ready  output  1: requester A request accepted this cycle.
REQ-006 SHALL have ports b_valid input 1, b_x input 6, b_y input 6, b_color input 12: requester B (host/SPI) write request.
REQ-007 SHALL have port b_ready  output  1: requester B request accepted this cycle.
REQ-008 SHALL have port clear_req  input  1: request a full-frame clear, sampled every cycle.
REQ-009 SHALL have port clear_busy  output  1: clear sweep in progress.
REQ-010 SHALL have ports write_en output 1, write_x output 6, write_y output 6, write_color output 12: registered pixel memory write port.

Function
REQ-011 SHALL implement states ARB and CLEAR.
REQ-012 A transfer SHALL occur when x_valid and x_ready are both high in the same cycle.
REQ-013 a_ready and b_ready SHALL be combinational, never both high, and both low in CLEAR.
REQ-014 In ARB with only one valid, that requester SHALL get ready.
REQ-015 In ARB with both valid, the requester not granted most recently SHALL get ready (round-robin).
REQ-016 The last-grant pointer SHALL update only on a transfer, recording the granted requester.
REQ-017 A transfer in cycle t SHALL produce write_en=1 with the transferred x, y and colour in cycle t+1 (1-cycle latency).
REQ-018 write_en SHALL be 0 in any cycle after one with no transfer and no clear write; write_x/y/color SHALL hold their last values.
REQ-019 In ARB, clear_req=1 SHALL take priority: both readies 0 that cycle, state CLEAR next cycle with the 12-bit sweep counter at 0.
REQ-020 In CLEAR, each cycle with counter k SHALL produce, next cycle, write_en=1, write_x=k[5:0], write_y=k[11:6], write_color=CLEAR_COLOR.
REQ-021 At k=4095, the counter SHALL wrap to 0 and the state SHALL return to ARB; exactly 4096 writes per clear.
REQ-022 clear_req during CLEAR SHALL be ignored and not queued.
REQ-023 clear_busy SHALL equal (state==CLEAR).
REQ-024 A requester holding valid SHALL stay pending with its x/y/colour stable until its transfer.

Reset
REQ-025 rst_n low SHALL asynchronously force ARB, sweep counter 0, last-grant pointer to B (A wins first contention), write_en 0, write_x 0, write_y 0, write_color 0, clear_busy 0.
REQ-026 Reset mid-clear SHALL abandon the sweep; no further clear writes after rst_n rises.

Configuration
REQ-027 With PIXEL_ARB_CLEAR_EN defined, the CLEAR state, sweep counter and CLEAR_COLOR SHALL be compiled in per REQ-019..023.
REQ-028 Without PIXEL_ARB_CLEAR_EN, CLEAR logic SHALL be absent, clear_req ignored, clear_busy tied 0, arbitration unchanged.

Verification
REQ-029 Reset release, no valids -> write_en=0, outputs 0, clear_busy=0 for 10 cycles.
REQ-030 a_valid=1 for one cycle with (5,10,12'hF00) -> a_ready=1 that cycle; next cycle write_en=1, (5,10,12'hF00); following cycle write_en=0.
REQ-031 a_valid and b_valid held high 4 cycles after reset -> grants A,B,A,B; four consecutive writes with matching data.
REQ-032 (PIXEL_ARB_CLEAR_EN) clear_req pulse at t -> clear_busy high t+1..t+4096; write_en high t+2..t+4097; first (0,0), last (63,63), colour CLEAR_COLOR; readies 0 throughout.
REQ-033 (PIXEL_ARB_CLEAR_EN) clear_req and a_valid both high at t, a_valid held -> a_ready=0 until t+4097, then A's write 1 cycle later.
REQ-034 (PIXEL_ARB_CLEAR_EN) rst_n low at clear write 100 -> write_en=0 immediately, clear_busy=0; after release, no further writes without valid.
